// File: rtl/aer_lrf_scatter_seq_if.sv
// Handshake bundle between the input AER router, the LRF scatter mapper and the core array.
// master = router/core-array side, slave = the mapper.
interface aer_lrf_scatter_seq_if #(
    parameter int N_CORES           = 36,
    parameter int MAP_IN_AER_WIDTH  = 10,
    parameter int MAP_OUT_AER_WIDTH = 8
);
    logic                                              MAP_IN_AERIN_REQ;
    logic [MAP_IN_AER_WIDTH-1:0]                       MAP_IN_AERIN_EVENT;
    logic [MAP_IN_AER_WIDTH-3:0]                       MAP_IN_AERIN_IDX;
    logic                                              MAP_IN_AERIN_ACK;
    logic [N_CORES-1:0]                                MAP_OUT_AERIN_REQ;
    logic [N_CORES-1:0][MAP_OUT_AER_WIDTH-1:0]         MAP_OUT_AERIN_EVENT;
    logic [N_CORES-1:0][MAP_OUT_AER_WIDTH-3:0]         MAP_OUT_AERIN_IDX;
    logic [N_CORES-1:0]                                MAP_OUT_AERIN_ACK;
    logic                                              BUSY;
    logic                                              TIMEOUT_ERR;

    modport master (
        output MAP_IN_AERIN_REQ, MAP_IN_AERIN_EVENT, MAP_IN_AERIN_IDX, MAP_OUT_AERIN_ACK,
        input  MAP_IN_AERIN_ACK, MAP_OUT_AERIN_REQ, MAP_OUT_AERIN_EVENT, MAP_OUT_AERIN_IDX,
               BUSY, TIMEOUT_ERR
    );

    modport slave (
        input  MAP_IN_AERIN_REQ, MAP_IN_AERIN_EVENT, MAP_IN_AERIN_IDX, MAP_OUT_AERIN_ACK,
        output MAP_IN_AERIN_ACK, MAP_OUT_AERIN_REQ, MAP_OUT_AERIN_EVENT, MAP_OUT_AERIN_IDX,
               BUSY, TIMEOUT_ERR
    );
endinterface

// File: rtl/aer_lrf_scatter_seq.sv
// Sequential LRF scatter: maps one input AER event to every core whose receptive field holds
// the pixel, runs all hit-core four-phase handshakes in parallel, then acks the input.
module aer_lrf_scatter_seq #(
    parameter int FM_C              = 4,
    parameter int FM_W              = 8,
    parameter int FM_H              = 8,
    parameter int LRF_W             = 3,
    parameter int LRF_H             = 3,
    parameter int STRIDE            = 1,
    parameter int PAD               = 0,
    parameter int MAP_IN_AER_WIDTH  = 10,
    parameter int MAP_OUT_AER_WIDTH = 8,
    parameter int TIMEOUT           = 1023
) (
    input logic                  clk,
    input logic                  rst,
    aer_lrf_scatter_seq_if.slave bus
);
    localparam int CORE_W    = (FM_W + 2*PAD - LRF_W) / STRIDE + 1;
    localparam int CORE_H    = (FM_H + 2*PAD - LRF_H) / STRIDE + 1;
    localparam int N_CORES   = CORE_W * CORE_H;
    localparam int X_BITS    = (FM_W  > 1) ? $clog2(FM_W)  : 1;
    localparam int Y_BITS    = (FM_H  > 1) ? $clog2(FM_H)  : 1;
    localparam int C_BITS    = (FM_C  > 1) ? $clog2(FM_C)  : 1;
    localparam int DX_BITS   = (LRF_W > 1) ? $clog2(LRF_W) : 1;
    localparam int DY_BITS   = (LRF_H > 1) ? $clog2(LRF_H) : 1;
    localparam int OUT_IDX_W = MAP_OUT_AER_WIDTH - 2;
    localparam int AW        = $clog2(((FM_W > FM_H) ? FM_W : FM_H) + 2*PAD + 1);
    localparam int TO_BITS   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DISPATCH, ACK_IN} state_t;

    state_t                                     state;
    logic [1:0]                                 lat_type;
    logic [C_BITS-1:0]                          lat_c;
    logic [Y_BITS-1:0]                          lat_y;
    logic [X_BITS-1:0]                          lat_x;
    logic                                       in_ack;
    logic                                       busy;
    logic                                       timeout_err;
    logic [N_CORES-1:0]                         out_req;
    logic [N_CORES-1:0]                         pending;
    logic [N_CORES-1:0][MAP_OUT_AER_WIDTH-1:0]  out_event;
    logic [N_CORES-1:0][OUT_IDX_W-1:0]          out_idx;
    logic [TO_BITS-1:0]                         stall_cnt;

    logic [AW-1:0]                              xp, yp;
    logic [N_CORES-1:0]                         hit_mask;
    logic [N_CORES-1:0][OUT_IDX_W-1:0]          hit_idx;
    logic [N_CORES-1:0]                         calc_mask;
    logic [N_CORES-1:0][OUT_IDX_W-1:0]          calc_idx;
    logic [N_CORES-1:0][MAP_OUT_AER_WIDTH-1:0]  calc_event;
    logic [N_CORES-1:0]                         req_next, clear, pend_next;
    logic [TO_BITS-1:0]                         stall_inc;
    logic                                       timeout_hit;
    logic                                       unused_evt_bits;

    assign unused_evt_bits = ^bus.MAP_IN_AERIN_EVENT[MAP_IN_AER_WIDTH-3:0];

    assign xp = AW'(lat_x) + AW'(PAD);
    assign yp = AW'(lat_y) + AW'(PAD);

    // A pixel left of a window wraps the subtraction far above LRF_W, so one compare per axis
    // covers both window bounds.
    for (genvar oy = 0; oy < CORE_H; oy++) begin : g_row
        for (genvar ox = 0; ox < CORE_W; ox++) begin : g_col
            localparam logic [AW-1:0] X_BASE = AW'(ox * STRIDE);
            localparam logic [AW-1:0] Y_BASE = AW'(oy * STRIDE);
            logic [AW-1:0] dx_full, dy_full;

            assign dx_full = xp - X_BASE;
            assign dy_full = yp - Y_BASE;
            assign hit_mask[oy*CORE_W + ox] = (dx_full < AW'(LRF_W)) && (dy_full < AW'(LRF_H));
            assign hit_idx[oy*CORE_W + ox]  =
                OUT_IDX_W'({lat_c, dy_full[DY_BITS-1:0], dx_full[DX_BITS-1:0]});
        end
    end

    // NOTE: every variable gets a default before the case so no path holds an old value,
    // which would otherwise infer a latch.
    always_comb begin
        calc_mask  = '0;
        calc_idx   = '0;
        calc_event = '0;
        unique case (lat_type)
            2'b00: begin
                calc_mask = hit_mask;
                calc_idx  = hit_idx;
                for (int i = 0; i < N_CORES; i++) calc_event[i] = {lat_type, hit_idx[i]};
            end
            2'b01, 2'b10: begin
                calc_mask = '1;
                for (int i = 0; i < N_CORES; i++) calc_event[i] = {lat_type, {OUT_IDX_W{1'b1}}};
            end
            default: ;
        endcase
    end

    // A core's handshake is complete once both its REQ and ACK are back low.
    assign req_next    = out_req & ~bus.MAP_OUT_AERIN_ACK;
    assign clear       = pending & ~out_req & ~bus.MAP_OUT_AERIN_ACK;
    assign pend_next   = pending & ~clear;
    assign stall_inc   = stall_cnt + 1'b1;
    assign timeout_hit = (TIMEOUT != 0) && (clear == '0) && (stall_inc == TO_BITS'(TIMEOUT));

    // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values,
    // independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lat_type    <= '0;
            lat_c       <= '0;
            lat_y       <= '0;
            lat_x       <= '0;
            in_ack      <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            out_req     <= '0;
            pending     <= '0;
            stall_cnt   <= '0;
            // NOTE: the per-core EVENT/IDX banks drive module outputs, so they are reset
            // like any other register rather than left as unreset storage.
            out_event   <= '0;
            out_idx     <= '0;
        end else begin
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.MAP_IN_AERIN_REQ) begin
                        lat_type <= bus.MAP_IN_AERIN_EVENT[MAP_IN_AER_WIDTH-1 -: 2];
                        lat_x    <= bus.MAP_IN_AERIN_IDX[X_BITS-1:0];
                        lat_y    <= bus.MAP_IN_AERIN_IDX[X_BITS +: Y_BITS];
                        lat_c    <= bus.MAP_IN_AERIN_IDX[X_BITS+Y_BITS +: C_BITS];
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    out_event <= calc_event;
                    out_idx   <= calc_idx;
                    stall_cnt <= '0;
                    if (calc_mask == '0) begin
                        in_ack <= 1'b1;
                        state  <= ACK_IN;
                    end else begin
                        pending <= calc_mask;
                        out_req <= calc_mask;
                        state   <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    if (pend_next == '0) begin
                        out_req <= '0;
                        pending <= '0;
                        in_ack  <= 1'b1;
                        state   <= ACK_IN;
                    end else if (timeout_hit) begin
                        out_req     <= '0;
                        pending     <= '0;
                        timeout_err <= 1'b1;
                        in_ack      <= 1'b1;
                        state       <= ACK_IN;
                    end else begin
                        out_req   <= req_next;
                        pending   <= pend_next;
                        stall_cnt <= (clear != '0) ? '0 : stall_inc;
                    end
                end
                ACK_IN: begin
                    if (!bus.MAP_IN_AERIN_REQ) begin
                        in_ack <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.MAP_IN_AERIN_ACK    = in_ack;
    assign bus.MAP_OUT_AERIN_REQ   = out_req;
    assign bus.MAP_OUT_AERIN_EVENT = out_event;
    assign bus.MAP_OUT_AERIN_IDX   = out_idx;
    assign bus.BUSY                = busy;
    assign bus.TIMEOUT_ERR         = timeout_err;
endmodule

// File: tb/tb_aer_lrf_scatter_seq.sv
// Bench for aer_lrf_scatter_seq: three geometries (default, STRIDE=2, TIMEOUT=8) driven through
// one shared stimulus/observation path selected by `sel`, checked against a window-enumeration model.
module tb_aer_lrf_scatter_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aer_lrf_scatter_seq_if #(.N_CORES(36), .MAP_IN_AER_WIDTH(10), .MAP_OUT_AER_WIDTH(8)) bus_d ();
    aer_lrf_scatter_seq_if #(.N_CORES(9),  .MAP_IN_AER_WIDTH(10), .MAP_OUT_AER_WIDTH(8)) bus_s ();
    aer_lrf_scatter_seq_if #(.N_CORES(36), .MAP_IN_AER_WIDTH(10), .MAP_OUT_AER_WIDTH(8)) bus_t ();

    aer_lrf_scatter_seq u_def (.clk(clk), .rst(rst), .bus(bus_d));
    aer_lrf_scatter_seq #(.STRIDE(2)) u_s2 (.clk(clk), .rst(rst), .bus(bus_s));
    aer_lrf_scatter_seq #(.TIMEOUT(8)) u_to (.clk(clk), .rst(rst), .bus(bus_t));

    int          sel;
    logic        drv_req;
    logic [9:0]  drv_evt;
    logic [7:0]  drv_idx;
    logic [63:0] drv_ack;

    assign bus_d.MAP_IN_AERIN_REQ   = (sel == 0) && drv_req;
    assign bus_s.MAP_IN_AERIN_REQ   = (sel == 1) && drv_req;
    assign bus_t.MAP_IN_AERIN_REQ   = (sel == 2) && drv_req;
    assign bus_d.MAP_IN_AERIN_EVENT = drv_evt;
    assign bus_s.MAP_IN_AERIN_EVENT = drv_evt;
    assign bus_t.MAP_IN_AERIN_EVENT = drv_evt;
    assign bus_d.MAP_IN_AERIN_IDX   = drv_idx;
    assign bus_s.MAP_IN_AERIN_IDX   = drv_idx;
    assign bus_t.MAP_IN_AERIN_IDX   = drv_idx;
    assign bus_d.MAP_OUT_AERIN_ACK  = (sel == 0) ? drv_ack[35:0] : '0;
    assign bus_s.MAP_OUT_AERIN_ACK  = (sel == 1) ? drv_ack[8:0]  : '0;
    assign bus_t.MAP_OUT_AERIN_ACK  = (sel == 2) ? drv_ack[35:0] : '0;

    logic [63:0]      obs_req;
    logic [63:0][7:0] obs_evt;
    logic [63:0][5:0] obs_idx;
    logic             obs_in_ack, obs_busy, obs_to;

    always_comb begin
        obs_req    = '0;
        obs_evt    = '0;
        obs_idx    = '0;
        obs_in_ack = 1'b0;
        obs_busy   = 1'b0;
        obs_to     = 1'b0;
        case (sel)
            1: begin
                obs_req[8:0] = bus_s.MAP_OUT_AERIN_REQ;
                for (int i = 0; i < 9; i++) begin
                    obs_evt[i] = bus_s.MAP_OUT_AERIN_EVENT[i];
                    obs_idx[i] = bus_s.MAP_OUT_AERIN_IDX[i];
                end
                obs_in_ack = bus_s.MAP_IN_AERIN_ACK;
                obs_busy   = bus_s.BUSY;
                obs_to     = bus_s.TIMEOUT_ERR;
            end
            2: begin
                obs_req[35:0] = bus_t.MAP_OUT_AERIN_REQ;
                for (int i = 0; i < 36; i++) begin
                    obs_evt[i] = bus_t.MAP_OUT_AERIN_EVENT[i];
                    obs_idx[i] = bus_t.MAP_OUT_AERIN_IDX[i];
                end
                obs_in_ack = bus_t.MAP_IN_AERIN_ACK;
                obs_busy   = bus_t.BUSY;
                obs_to     = bus_t.TIMEOUT_ERR;
            end
            default: begin
                obs_req[35:0] = bus_d.MAP_OUT_AERIN_REQ;
                for (int i = 0; i < 36; i++) begin
                    obs_evt[i] = bus_d.MAP_OUT_AERIN_EVENT[i];
                    obs_idx[i] = bus_d.MAP_OUT_AERIN_IDX[i];
                end
                obs_in_ack = bus_d.MAP_IN_AERIN_ACK;
                obs_busy   = bus_d.BUSY;
                obs_to     = bus_d.TIMEOUT_ERR;
            end
        endcase
    end

    int          n_checks;
    int          n_pass;
    logic [63:0] exp_mask;
    logic [5:0]  exp_idx [64];
    logic [7:0]  exp_evt [64];

    // Reference: enumerate every offset inside a 3x3 window and ask which window origin
    // (if any, on the stride grid and inside the core array) would place the pixel there.
    task automatic model_event(input int typ, input int c, input int y, input int x);
        int s, cw, bx, by, core;
        s  = (sel == 1) ? 2 : 1;
        cw = (sel == 1) ? 3 : 6;
        exp_mask = '0;
        for (int i = 0; i < 64; i++) begin
            exp_idx[i] = '0;
            exp_evt[i] = '0;
        end
        if (typ == 1 || typ == 2) begin
            for (int i = 0; i < cw*cw; i++) begin
                exp_mask[i] = 1'b1;
                exp_evt[i]  = 8'(typ*64 + 63);
            end
        end else if (typ == 0) begin
            for (int dy = 0; dy < 3; dy++) begin
                for (int dx = 0; dx < 3; dx++) begin
                    bx = x - dx;
                    by = y - dy;
                    if (bx >= 0 && by >= 0 && bx % s == 0 && by % s == 0 && bx/s < cw && by/s < cw) begin
                        core           = (by/s)*cw + bx/s;
                        exp_mask[core] = 1'b1;
                        exp_idx[core]  = 6'(c*16 + dy*4 + dx);
                        exp_evt[core]  = 8'(c*16 + dy*4 + dx);
                    end
                end
            end
        end
    endtask

    // Drives one event and acts as every core: random ACK delay, random ACK hold after REQ
    // falls (the last hit core holds 5 cycles), an optional never-acking core and an optional
    // spurious ACK on a core outside the mask.
    task automatic run_event(input string name, input int typ, input int c, input int y,
                             input int x, input int stuck, input int spur, input bit exp_to);
        logic [63:0] ack, done, raised;
        int          delay [64];
        int          hold  [64];
        int          pulses, last;
        bit          finished;
        model_event(typ, c, y, x);
        ack = '0; done = '0; raised = '0; pulses = 0; last = -1; finished = 0;
        if (spur >= 0) ack[spur] = 1'b1;
        for (int i = 0; i < 64; i++) begin
            delay[i] = $urandom_range(0, 4);
            hold[i]  = $urandom_range(0, 2);
            if (exp_mask[i]) last = i;
        end
        if (last >= 0) hold[last] = 5;
        drv_ack = ack;
        drv_evt = {typ[1:0], c[1:0], y[2:0], x[2:0]};
        drv_idx = {c[1:0], y[2:0], x[2:0]};
        drv_req = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (obs_req !== '0 || obs_in_ack !== 1'b0 || obs_busy !== 1'b1)
            $display("FAIL %s latch: req=%h ack=%b busy=%b, want req=0 ack=0 busy=1",
                     name, obs_req, obs_in_ack, obs_busy);
        else n_pass++;
        drv_evt = 10'($urandom);
        drv_idx = 8'($urandom);
        @(posedge clk); #1;
        n_checks++;
        if (obs_req !== exp_mask || obs_in_ack !== (exp_mask == '0))
            $display("FAIL %s calc: req=%h in_ack=%b, want req=%h in_ack=%b",
                     name, obs_req, obs_in_ack, exp_mask, exp_mask == '0);
        else n_pass++;
        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            if (obs_to) pulses++;
            for (int i = 0; i < 64; i++) begin
                if (raised[i]) begin
                    n_checks++;
                    if (obs_req[i] !== 1'b0)
                        $display("FAIL %s req_drop core %0d: req=%b, want 0", name, i, obs_req[i]);
                    else n_pass++;
                end
                if (obs_req[i]) begin
                    n_checks++;
                    if (!exp_mask[i] || obs_evt[i] !== exp_evt[i] || obs_idx[i] !== exp_idx[i])
                        $display("FAIL %s core %0d: evt=%h idx=%h in_mask=%b, want evt=%h idx=%h in_mask=1",
                                 name, i, obs_evt[i], obs_idx[i], exp_mask[i], exp_evt[i], exp_idx[i]);
                    else n_pass++;
                end
            end
            if (obs_in_ack) begin
                finished = 1;
            end else begin
                raised = '0;
                for (int i = 0; i < 64; i++) begin
                    if (exp_mask[i]) begin
                        if (obs_req[i] && !ack[i]) begin
                            if (i != stuck) begin
                                if (delay[i] == 0) begin
                                    ack[i]    = 1'b1;
                                    raised[i] = 1'b1;
                                end else delay[i]--;
                            end
                        end else if (ack[i] && !obs_req[i]) begin
                            if (hold[i] == 0) begin
                                ack[i]  = 1'b0;
                                done[i] = 1'b1;
                            end else hold[i]--;
                        end
                    end
                end
                drv_ack = ack;
                @(posedge clk); #1;
            end
        end
        n_checks++;
        if (!finished) $display("FAIL %s in_ack: never rose within cycle budget", name);
        else n_pass++;
        n_checks++;
        if (exp_to) begin
            if (pulses != 1 || obs_req !== '0)
                $display("FAIL %s timeout: pulses=%0d req=%h, want pulses=1 req=0", name, pulses, obs_req);
            else n_pass++;
        end else begin
            if (done !== exp_mask || pulses != 0)
                $display("FAIL %s completion: done=%h pulses=%0d, want done=%h pulses=0",
                         name, done, pulses, exp_mask);
            else n_pass++;
        end
        drv_req = 1'b0;
        drv_ack = '0;
        @(posedge clk); #1;
        n_checks++;
        if (obs_in_ack !== 1'b0 || obs_busy !== 1'b0 || obs_to !== 1'b0 || obs_req !== '0)
            $display("FAIL %s release: in_ack=%b busy=%b to=%b req=%h, want all 0",
                     name, obs_in_ack, obs_busy, obs_to, obs_req);
        else n_pass++;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            n_checks++;
            if (obs_req !== '0 || obs_evt !== '0 || obs_idx !== '0 || obs_in_ack !== 1'b0 ||
                obs_busy !== 1'b0 || obs_to !== 1'b0)
                $display("FAIL reset dut%0d: req=%h ack=%b busy=%b to=%b, want all 0",
                         s, obs_req, obs_in_ack, obs_busy, obs_to);
            else n_pass++;
        end
        sel = 0;
    endtask

    task automatic test_spike_center();
        sel = 0;
        run_event("center_c1_y3_x3", 0, 1, 3, 3, -1, 0, 0);
    endtask

    task automatic test_corners();
        sel = 0;
        run_event("corner_origin", 0, 0, 0, 0, -1, -1, 0);
        run_event("corner_far", 0, 0, 7, 7, -1, -1, 0);
        run_event("edge_c3_y0_x4", 0, 3, 0, 4, -1, 35, 0);
    endtask

    task automatic test_stride2();
        sel = 1;
        run_event("s2_x2_y0", 0, 2, 0, 2, -1, -1, 0);
        run_event("s2_gap_x7", 0, 1, 0, 7, -1, -1, 0);
        run_event("s2_x4_y4", 0, 3, 4, 4, -1, -1, 0);
        sel = 0;
    endtask

    task automatic test_control_invalid();
        sel = 0;
        run_event("ctrl_type01", 1, 2, 5, 1, -1, -1, 0);
        run_event("ctrl_type10", 2, 0, 0, 0, -1, -1, 0);
        run_event("invalid_type11", 3, 1, 3, 3, -1, -1, 0);
    endtask

    task automatic test_timeout();
        sel = 2;
        run_event("timeout_stuck14", 0, 1, 3, 3, 14, -1, 1);
        run_event("timeout_recover", 0, 2, 2, 6, -1, -1, 0);
        sel = 0;
    endtask

    task automatic test_reset_mid_dispatch();
        sel = 0;
        model_event(0, 2, 4, 4);
        drv_ack = '0;
        drv_evt = {2'b00, 2'd2, 3'd4, 3'd4};
        drv_idx = {2'd2, 3'd4, 3'd4};
        drv_req = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        n_checks++;
        if (obs_req !== exp_mask) $display("FAIL pre_reset req=%h, want %h", obs_req, exp_mask);
        else n_pass++;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs_req !== '0 || obs_evt !== '0 || obs_idx !== '0 || obs_in_ack !== 1'b0 ||
            obs_busy !== 1'b0 || obs_to !== 1'b0)
            $display("FAIL async_reset: req=%h ack=%b busy=%b, want all 0", obs_req, obs_in_ack, obs_busy);
        else n_pass++;
        drv_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_event("post_reset", 0, 3, 5, 2, -1, -1, 0);
    endtask

    task automatic test_random();
        int r, typ;
        for (int k = 0; k < 30; k++) begin
            sel = $urandom_range(0, 1);
            r   = $urandom_range(0, 5);
            typ = (r < 3) ? 0 : r - 2;
            run_event("random", typ, $urandom_range(0, 3), $urandom_range(0, 7),
                      $urandom_range(0, 7), -1, -1, 0);
        end
        sel = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        sel      = 0;
        drv_req  = 1'b0;
        drv_evt  = '0;
        drv_idx  = '0;
        drv_ack  = '0;
        rst      = 1'b1;
        #2;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        test_spike_center();
        test_corners();
        test_stride2();
        test_control_invalid();
        test_timeout();
        test_reset_mid_dispatch();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/aer_lrf_scatter_seq.md
Name: aer_lrf_scatter_seq

Overview:
Sequential successor to the combinational LRF mapper. It takes one input AER event over a four-phase handshake and computes which cores' local receptive fields contain the pixel, with generalised stride and zero-padding. It then dispatches the event to all hit cores in parallel, tracking each core's four-phase handshake independently, and acknowledges the input only when every hit core has completed. It sits between the input AER router and the core array of the SNN_FF datapath.

Parameters:
- FM_C, 4: input channels.
- FM_W, 8: input feature-map width.
- FM_H, 8: input feature-map height.
- LRF_W, 3: receptive-field width.
- LRF_H, 3: receptive-field height.
- STRIDE, 1: window stride, same in x and y, must be >= 1.
- PAD, 0: zero-padding on each border, must be < LRF_W and < LRF_H.
- MAP_IN_AER_WIDTH, 10: input event width = 2 + C_BITS + Y_BITS + X_BITS.
- MAP_OUT_AER_WIDTH, 8: output event width; must be >= 2 + C_BITS + DY_BITS + DX_BITS.
- TIMEOUT, 1023: dispatch stall limit in cycles; 0 disables the timeout.
- Derived, not overridable:
  - CORE_W = (FM_W + 2*PAD - LRF_W)/STRIDE + 1
  - CORE_H = (FM_H + 2*PAD - LRF_H)/STRIDE + 1
  - X/Y/C_BITS = clog2 of FM_W / FM_H / FM_C
  - DX/DY_BITS = clog2 of LRF_W / LRF_H

Ports:
- clk, in, 1: single clock.
- rst, in, 1: reset, asynchronous, active-high.
- MAP_IN_AERIN_REQ, in, 1: input four-phase request.
- MAP_IN_AERIN_EVENT, in, MAP_IN_AER_WIDTH: [MSB -: 2] = event type.
- MAP_IN_AERIN_IDX, in, MAP_IN_AER_WIDTH-2: packed {c, y, x}.
- MAP_IN_AERIN_ACK, out, 1: input acknowledge.
- MAP_OUT_AERIN_REQ, out, CORE_W*CORE_H: per-core request; core id = oy*CORE_W + ox.
- MAP_OUT_AERIN_EVENT, out, CORE_W*CORE_H x MAP_OUT_AER_WIDTH: per-core event.
- MAP_OUT_AERIN_IDX, out, CORE_W*CORE_H x (MAP_OUT_AER_WIDTH-2): per-core local index.
- MAP_OUT_AERIN_ACK, in, CORE_W*CORE_H: per-core acknowledge.
- BUSY, out, 1: state != IDLE.
- TIMEOUT_ERR, out, 1: one-cycle pulse when the stall limit is hit.

Behaviour:
- Reset (async, any state): state = IDLE; all REQ, ACK, BUSY and TIMEOUT_ERR = 0; EVENT/IDX registers = 0; pending mask cleared; stall counter = 0.
- All outputs are registered.

IDLE:
- When MAP_IN_AERIN_REQ = 1 at an edge, latch type, c, y, x and go to CALC.
- The latched copy is used thereafter; input EVENT/IDX may change after latching.

CALC (exactly 1 cycle):
- Build the hit mask in parallel. Core (ox, oy) is hit iff:
  - xp = x + PAD satisfies ox*STRIDE <= xp < ox*STRIDE + LRF_W, and
  - yp = y + PAD satisfies the same test against oy*STRIDE and LRF_H.
- Local offsets: dx = xp - ox*STRIDE, dy = yp - oy*STRIDE.
- Output IDX = {c, dy, dx}, zero-extended to MAP_OUT_AER_WIDTH-2. Output EVENT = {type, IDX[MAP_OUT_AER_WIDTH-3:0]}.
- All arithmetic is unsigned and wide enough to hold FM_W + 2*PAD without wrap.
- Type handling:
  - Type 00 (spike): use the hit mask.
  - Types 01 and 10 (control): mask = all ones; IDX = 0; EVENT = {type, all ones}.
  - Type 11 (invalid): mask = 0.
- If mask = 0 (type 11, or a pixel falling in a stride gap or outside every window), go to ACK_IN; no core sees a REQ.
- Otherwise load pending = mask, set REQ = mask, and go to DISPATCH.
- Output REQ rises at the 2nd edge after the input REQ is sampled.

DISPATCH:
- Per core i, on the edge where REQ[i] = 1 and ACK[i] = 1: REQ[i] <= 0.
- pending[i] clears on the first edge where REQ[i] = 0 and ACK[i] = 0.
- Acks may arrive in any order, or all in the same cycle.
- Leave DISPATCH when pending = 0, going to ACK_IN.
- An ACK from a core not in the mask is ignored.

ACK_IN:
- Set MAP_IN_AERIN_ACK = 1.
- When MAP_IN_AERIN_REQ = 0, clear the ACK and go to IDLE.
- A new event can be accepted no earlier than the cycle after the ACK falls.

Timeout:
- The stall counter increments each cycle in DISPATCH and resets on any pending-bit clear.
- On reaching TIMEOUT: pulse TIMEOUT_ERR, clear all REQ and pending, and go to ACK_IN; the event is dropped.

Hold and sequencing rules:
- Output EVENT/IDX are stable while the corresponding REQ = 1.
- Input REQ falling before ACK is a protocol violation; the event is still fully dispatched.

Test Plan:
- Defaults, spike c=1, y=3, x=3 -> REQ high on cores {7,8,9,13,14,15,19,20,21}.
  - Core 7 IDX = 0x1A (dy=2, dx=2); core 21 IDX = 0x10.
  - Input ACK only after all 9 core handshakes complete.
- Defaults, spike x=0, y=0, c=0 -> only core 0 requested with IDX = 0x00; corner x=7, y=7 -> only core 35 with dy=2, dx=2.
- STRIDE=2 (CORE_W=CORE_H=3):
  - x=2, y=0 -> cores 0 and 1 with dx=2 and dx=0.
  - x=7 -> no core requested; input ACKed at the 2nd edge with zero output REQ.
- Control and invalid events:
  - Type 01 -> all 36 REQs high, IDX=0, EVENT=0x7F.
  - Type 11 -> no REQ, input ACKed.
- Staggered ACKs (cores 7..21 ACK at different cycles, one core holding ACK high for 5 cycles) -> each REQ drops the edge after its own ACK; input ACK waits for the last ACK to fall.
- TIMEOUT=8 with one hit core never ACKing -> TIMEOUT_ERR pulses once, all REQ = 0, input ACKed.
- Reset asserted mid-DISPATCH -> all outputs 0 asynchronously; the next event after reset processes normally.
